// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// buffers returned words with their PC in a small FIFO toward decode.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  ST_REQ  | offering a request at r_pc whenever the FIFO has room
//  ST_WAIT | one request accepted, waiting for its in-order response
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4
);

    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);

    typedef enum logic {ST_REQ = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_drop;
    logic [CW-1:0]   r_count;
    logic [IW-1:0]   r_head;
    logic [IW-1:0]   r_tail;
    logic [31:0]     r_fifo_instr [BUF_DEPTH];
    logic [XLEN-1:0] r_fifo_pc    [BUF_DEPTH];

    logic            w_req_fire;
    logic            w_rsp_take;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_target;

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IW'(1);
    endfunction

    // Outputs are forced low during the reset cycle, before the registers clear.
    assign imem_req_valid = !reset && (r_state == ST_REQ) && (r_count < DEPTH_C);
    assign imem_addr      = r_pc;
    assign instr_valid    = !reset && (r_count != '0);
    assign instr          = r_fifo_instr[r_head];
    assign instr_pc       = r_fifo_pc[r_head];
    assign instr_pcplus4  = r_fifo_pc[r_head] + XLEN'(4);

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_take = (r_state == ST_WAIT) && imem_rsp_valid;
    assign w_push     = w_rsp_take && !r_drop && !PCSrc;
    assign w_pop      = instr_valid && instr_ready;
    assign w_target   = PCTarget & ~(XLEN'(3));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_REQ;
            r_pc     <= RESET_PC;
            r_req_pc <= RESET_PC;
            r_drop   <= 1'b0;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
        end else begin
            case (r_state)
                ST_REQ:  if (w_req_fire) r_state <= ST_WAIT;
                ST_WAIT: if (imem_rsp_valid) r_state <= ST_REQ;
                default: r_state <= ST_REQ;
            endcase

            if (w_req_fire)
                r_req_pc <= r_pc;

            if (PCSrc)
                r_pc <= w_target;
            else if (w_req_fire)
                r_pc <= r_pc + XLEN'(4);

            // A request still in flight after a redirect must have its response dropped.
            if (PCSrc)
                r_drop <= ((r_state == ST_WAIT) && !imem_rsp_valid) || w_req_fire;
            else if (w_rsp_take)
                r_drop <= 1'b0;

            if (w_push) begin
                r_fifo_instr[r_tail] <= imem_rsp_data;
                r_fifo_pc[r_tail]    <= r_req_pc;
            end

            if (PCSrc) begin
                r_count <= '0;
                r_head  <= '0;
                r_tail  <= '0;
            end else begin
                if (w_push)
                    r_tail <= ptr_next(r_tail);
                if (w_pop)
                    r_head <= ptr_next(r_head);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 1-cycle memory model inside the stimulus
// task, hand-computed expected PCs/addresses, immediate-assertion checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    int n_pass  = 0;
    int n_total = 0;
    int n_fire  = 0;
    int fire_mark;
    logic auto_rsp;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .PCTarget       (PCTarget),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tag(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    // One clock; with auto_rsp the memory answers exactly one cycle after acceptance.
    task automatic tick();
        logic        f;
        logic [31:0] a;
        f = imem_req_valid && imem_req_ready;
        a = imem_addr;
        if (f) n_fire++;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rsp_valid = f;
            imem_rsp_data  = tag(a);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; PCSrc = 1'b0; PCTarget = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        instr_ready = 1'b0; auto_rsp = 1'b1;
        tick();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);

        // Sequential fetch
        imem_req_ready = 1'b1; instr_ready = 1'b1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("seq_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * i));
            tick();
            tick();
            chk("seq_instr_pc", instr_pc, 32'(4 * i));
            chk("seq_pcplus4", instr_pcplus4, 32'(4 * i + 4));
            chk("seq_instr", instr, tag(32'(4 * i)));
        end

        // Backpressure: two entries fill the FIFO, fetch stalls at 0x8
        instr_ready = 1'b0;
        do_reset();
        tick(); tick(); tick(); tick();
        chk("bp_req_valid_full", {31'b0, imem_req_valid}, 32'd0);
        chk("bp_pc_hold", imem_addr, 32'h8);
        tick(); tick();
        chk("bp_still_stalled", {31'b0, imem_req_valid}, 32'd0);
        chk("bp_addr_stable", imem_addr, 32'h8);
        instr_ready = 1'b1;
        #1;
        chk("bp_head0", instr_pc, 32'h0);
        tick();
        chk("bp_head1", instr_pc, 32'h4);
        chk("bp_resume_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("bp_resume_addr", imem_addr, 32'h8);
        tick(); tick();
        chk("bp_after_resume", instr_pc, 32'h8);

        // Memory stall at PC=0x4
        do_reset();
        tick(); tick();
        imem_req_ready = 1'b0;
        fire_mark = n_fire;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_addr", imem_addr, 32'h4);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("stall_single_req", 32'(n_fire - fire_mark), 32'd1);
        tick();
        chk("stall_instr_pc", instr_pc, 32'h4);

        // Redirect while WAIT with 0x8 outstanding
        instr_ready = 1'b0; auto_rsp = 1'b0;
        tick();
        chk("rw_wait_fifo", {31'b0, instr_valid}, 32'd1);
        chk("rw_wait_noreq", {31'b0, imem_req_valid}, 32'd0);
        PCSrc = 1'b1; PCTarget = 32'h103;
        tick();
        PCSrc = 1'b0;
        chk("rw_flushed", {31'b0, instr_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = tag(32'h8);
        tick();
        imem_rsp_valid = 1'b0;
        chk("rw_dropped", {31'b0, instr_valid}, 32'd0);
        chk("rw_target_addr", imem_addr, 32'h100);
        auto_rsp = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        chk("rw_first_pc", instr_pc, 32'h100);
        chk("rw_first_instr", instr, tag(32'h100));

        // Redirect coincident with request handshake at 0xC and a pop
        do_reset();
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("rc_addr_c", imem_addr, 32'hC);
        chk("rc_popped_pc", instr_pc, 32'h8);
        PCSrc = 1'b1; PCTarget = 32'h102;
        fire_mark = n_fire;
        tick();
        PCSrc = 1'b0;
        chk("rc_req_fired", 32'(n_fire - fire_mark), 32'd1);
        chk("rc_flushed", {31'b0, instr_valid}, 32'd0);
        tick();
        chk("rc_dropped", {31'b0, instr_valid}, 32'd0);
        chk("rc_target_addr", imem_addr, 32'h100);
        tick(); tick();
        chk("rc_first_pc", instr_pc, 32'h100);

        // Reset in WAIT; the abandoned response arrives the cycle after reset
        instr_ready = 1'b0; auto_rsp = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rw_reset_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rw_reset_instr_valid", {31'b0, instr_valid}, 32'd0);
        tick();
        reset = 1'b0;
        imem_rsp_valid = 1'b1; imem_rsp_data = tag(32'h104);
        #1;
        chk("rr_addr", imem_addr, 32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        #1;
        chk("rr_late_ignored", {31'b0, instr_valid}, 32'd0);
        imem_rsp_valid = 1'b1; imem_rsp_data = tag(32'h0);
        tick();
        imem_rsp_valid = 1'b0;
        chk("rr_new_valid", {31'b0, instr_valid}, 32'd1);
        chk("rr_new_instr", instr, tag(32'h0));

        // Redirect near the top of the address space; PC+4 wraps to 0
        auto_rsp = 1'b1; instr_ready = 1'b1;
        PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFF;
        tick();
        PCSrc = 1'b0;
        tick();
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick(); tick();
        chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pcplus4", instr_pcplus4, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
